spike_frame_encoder: RTL and testbench
======================================

Name: spike_frame_encoder

Overview:
Upstream feeder for the spiking layer. Accepts a stream of pixel intensities over a valid/ready handshake, converts each pixel to a temporal spike time, and double-buffers one frame. It owns the global `time_val` counter and presents a complete, stable `spike_times` vector to the layer for exactly one time period per frame, swapping frames only at the window boundary.

Parameters:
NUM_SPIKES, 64, number of input spike lines (pixels per frame)
TIME_BITS, 3, log2 of time period; spike times and `time_val` are TIME_BITS+1 bits wide
TIME_PERIOD, 8, cycles per presentation window; equals 2**TIME_BITS
PIX_BITS, 8, pixel intensity width; must be >= TIME_BITS
NO_SPIKE_THRESH, 32, pixels strictly below this value encode as "no spike"

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pix_valid  in  1  pixel offered
pix_ready  out  1  encoder can accept a pixel this cycle
pix_data  in  PIX_BITS  pixel intensity
pix_last  in  1  final pixel of frame, qualified by pix_valid
time_val  out  TIME_BITS+1  window cycle counter, 0..TIME_PERIOD-1
spike_times  out  NUM_SPIKES*(TIME_BITS+1)  packed per-line spike times, line i at bits [i*(TIME_BITS+1) +: TIME_BITS+1]
frame_valid  out  1  spike_times holds a real frame for the current window
frame_start  out  1  one-cycle pulse, coincident with time_val==0 of a newly presented frame
frame_error  out  1  one-cycle pulse on a pix_last / count mismatch
frame_count  out  16  frames presented since reset, wraps at 2**16

Behaviour:
- Reset, sampled on the clk edge while rst=1: time_val=0; spike_times all = TIME_PERIOD (the no-spike code); frame_valid=0; frame_start=0; frame_error=0; frame_count=0; shadow buffer empty; load index=0. pix_ready=0 while rst=1.
- time_val: free-running. Increments each cycle and wraps from TIME_PERIOD-1 to 0. Wrap cycle = the cycle where time_val==TIME_PERIOD-1.
- Encoding, per accepted pixel p:
  - if p < NO_SPIKE_THRESH: code = TIME_PERIOD;
  - else: code = ((2**PIX_BITS-1) - p) >> (PIX_BITS-TIME_BITS), which lies in range 0..TIME_PERIOD-1.
  - Brighter pixels spike earlier. The code is written to shadow[load_idx] in the accept cycle.
- Handshake:
  - Accept = pix_valid & pix_ready.
  - pix_ready = !shadow_full & !rst (combinational from registered state).
  - pix_data and pix_last are sampled only on accept.
- Load index: 0..NUM_SPIKES-1. Increments on each accept.
  - Accept at index NUM_SPIKES-1: shadow_full<=1 and index<=0, regardless of pix_last. If pix_last=0, frame_error pulses next cycle.
  - Accept with pix_last=1 at index < NUM_SPIKES-1: entries above the index are filled with TIME_PERIOD, shadow_full<=1, index<=0, and frame_error pulses next cycle.
- Swap, at the wrap cycle:
  - If shadow_full=1: next cycle spike_times<=shadow, frame_valid<=1, frame_start<=1, frame_count+=1, shadow_full<=0.
  - If shadow_full=0: next cycle spike_times<=all TIME_PERIOD, frame_valid<=0, frame_start<=0.
  - Each frame is presented for exactly one window.
- spike_times changes only on the cycle time_val becomes 0. It is stable for all TIME_PERIOD cycles of the window.
- Simultaneous events: a final pixel accepted on the wrap cycle sets shadow_full, but the swap decision uses the pre-edge shadow_full=0. That frame is presented at the following wrap. pix_ready stays 0 until then.
- Latency: the final pixel is accepted at time_val=t. The frame appears at the next time_val==0 after the accept cycle, i.e. after TIME_PERIOD-1-t+1 cycles when t<TIME_PERIOD-1, or TIME_PERIOD+1 cycles when t=TIME_PERIOD-1.
- Reset mid-load or mid-window discards the partial shadow and the presented frame. All state returns to the reset values above.

Test Plan:
Bench configuration for all scenarios: NUM_SPIKES=4, TIME_BITS=3, TIME_PERIOD=8, PIX_BITS=8, NO_SPIKE_THRESH=32.
1. Reset, then release -> time_val counts 0..7,0..; spike_times={8,8,8,8}; frame_valid=0; pix_ready=1 the first cycle after release.
2. Send pixels {255,100,32,31} with pix_last on the 4th, back-to-back from time_val=0 -> pix_ready=0 from time_val=4. At the next time_val=0: spike_times={0,4,6,8}, frame_start pulses for 1 cycle, frame_valid=1, frame_count=1, pix_ready=1.
3. 4th pixel accepted exactly at time_val=7 -> no swap at that wrap (frame_valid=0 for that window). Frame presented 9 cycles after the accept. pix_ready=0 throughout.
4. pix_last asserted on the 2nd pixel, values {200,255} -> frame_error pulses once. At the next wrap: spike_times={1,0,8,8}.
5. Present one frame, then send nothing -> the following window shows spike_times={8,8,8,8}, frame_valid=0, no frame_start, frame_count unchanged.
6. Assert rst after 2 pixels accepted, then release and send {255,255,255,255} -> the first presented frame is {0,0,0,0} with no residue from the earlier pixels; frame_count=1.

Source files
------------

// File: rtl/spike_frame_encoder.sv
// Pixel-to-spike-time encoder with a double-buffered frame presented for one
// time window per frame, swapped only at the window boundary.
module spike_frame_encoder #(
   parameter int unsigned NUM_SPIKES      = 64,
   parameter int unsigned TIME_BITS       = 3,
   parameter int unsigned TIME_PERIOD     = 8,
   parameter int unsigned PIX_BITS        = 8,
   parameter int unsigned NO_SPIKE_THRESH = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  pix_valid,
   output logic                                  pix_ready,
   input  logic [PIX_BITS-1:0]                   pix_data,
   input  logic                                  pix_last,
   output logic [TIME_BITS:0]                    time_val,
   output logic [NUM_SPIKES*(TIME_BITS+1)-1:0]   spike_times,
   output logic                                  frame_valid,
   output logic                                  frame_start,
   output logic                                  frame_error,
   output logic [15:0]                           frame_count
);

   localparam int unsigned TW    = TIME_BITS + 1;
   localparam int unsigned IDX_W = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
   localparam int unsigned SHIFT = PIX_BITS - TIME_BITS;

   localparam logic [TW-1:0]              NO_SPIKE     = TW'(TIME_PERIOD);
   localparam logic [TW-1:0]              WRAP_TIME    = TW'(TIME_PERIOD - 1);
   localparam logic [IDX_W-1:0]           LAST_IDX     = IDX_W'(NUM_SPIKES - 1);
   localparam logic [PIX_BITS:0]          THRESH       = (PIX_BITS + 1)'(NO_SPIKE_THRESH);
   localparam logic [NUM_SPIKES*TW-1:0]   ALL_NO_SPIKE = {NUM_SPIKES{NO_SPIKE}};

   logic [NUM_SPIKES*TW-1:0] shadow;
   logic                     shadow_full;
   logic [IDX_W-1:0]         load_idx;
   logic                     accept;
   logic                     wrap;
   logic                     final_pix;
   logic [PIX_BITS-1:0]      pix_inv;
   logic [PIX_BITS-1:0]      pix_shifted;
   logic [TW-1:0]            code;

   assign pix_ready = !shadow_full && !rst;
   assign accept    = pix_valid && pix_ready;
   assign wrap      = (time_val == WRAP_TIME);
   assign final_pix = pix_last || (load_idx == LAST_IDX);

   // Brighter pixels map to earlier spike times; dim pixels never spike.
   always_comb begin
      pix_inv     = ~pix_data;
      pix_shifted = pix_inv >> SHIFT;
      code        = NO_SPIKE;
      if ({1'b0, pix_data} >= THRESH) begin
         code = TW'(pix_shifted);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         time_val <= '0;
      end else if (wrap) begin
         time_val <= '0;
      end else begin
         time_val <= time_val + TW'(1);
      end
   end

   // Shadow load: a short frame pads the unused lines with the no-spike code.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow      <= ALL_NO_SPIKE;
         shadow_full <= 1'b0;
         load_idx    <= '0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= accept && (pix_last != (load_idx == LAST_IDX));
         if (accept) begin
            for (int i = 0; i < int'(NUM_SPIKES); i++) begin
               if (IDX_W'(i) == load_idx) begin
                  shadow[i*TW +: TW] <= code;
               end else if (pix_last && (IDX_W'(i) > load_idx)) begin
                  shadow[i*TW +: TW] <= NO_SPIKE;
               end
            end
            load_idx <= final_pix ? '0 : load_idx + IDX_W'(1);
         end
         // An accept can only happen while the shadow is not full, so a final
         // pixel on the wrap cycle waits for the following wrap.
         if (accept && final_pix) begin
            shadow_full <= 1'b1;
         end else if (wrap && shadow_full) begin
            shadow_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spike_times <= ALL_NO_SPIKE;
         frame_valid <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else if (wrap) begin
         if (shadow_full) begin
            spike_times <= shadow;
            frame_valid <= 1'b1;
            frame_start <= 1'b1;
            frame_count <= frame_count + 16'd1;
         end else begin
            spike_times <= ALL_NO_SPIKE;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
         end
      end else begin
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spike_frame_encoder.sv
// Directed bench for spike_frame_encoder with a 4-line, 8-cycle configuration.
module tb_spike_frame_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_data;
   logic        pix_last;
   logic [3:0]  time_val;
   logic [15:0] spike_times;
   logic        frame_valid;
   logic        frame_start;
   logic        frame_error;
   logic [15:0] frame_count;

   int n_checks = 0;
   int n_fail   = 0;

   spike_frame_encoder #(
      .NUM_SPIKES(4), .TIME_BITS(3), .TIME_PERIOD(8), .PIX_BITS(8), .NO_SPIKE_THRESH(32)
   ) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_last(pix_last), .time_val(time_val),
      .spike_times(spike_times), .frame_valid(frame_valid), .frame_start(frame_start),
      .frame_error(frame_error), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pix(input logic [7:0] d, input logic l);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = l;
      tick();
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
      repeat (3) tick();
      n_checks++; if (time_val !== 4'd0) begin n_fail++; $display("FAIL reset_time_val got %0d exp 0", time_val); end
      n_checks++; if (spike_times !== 16'h8888) begin n_fail++; $display("FAIL reset_spike_times got %h exp 8888", spike_times); end
      n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid got %b exp 0", frame_valid); end
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
      n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error got %b exp 0", frame_error); end
      n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count got %0d exp 0", frame_count); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready got %b exp 0", pix_ready); end
      rst = 1'b0;
      #1;
      n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL release_pix_ready got %b exp 1", pix_ready); end
      for (int i = 1; i <= 16; i++) begin
         tick();
         n_checks++;
         if (time_val !== 4'(i % 8)) begin n_fail++; $display("FAIL time_val_count step %0d got %0d exp %0d", i, time_val, i % 8); end
      end
      n_checks++; if (spike_times !== 16'h8888 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL idle_window got st=%h fv=%b exp st=8888 fv=0", spike_times, frame_valid); end
   endtask

   task automatic sync_zero();
      int budget = 20;
      while (time_val !== 4'd0 && budget > 0) begin tick(); budget--; end
      n_checks++; if (time_val !== 4'd0) begin n_fail++; $display("FAIL sync_zero got %0d exp 0", time_val); end
   endtask

   task automatic test_frame();
      send_pix(8'd255, 1'b0);
      send_pix(8'd100, 1'b0);
      send_pix(8'd32,  1'b0);
      send_pix(8'd31,  1'b1);
      n_checks++; if (time_val !== 4'd4) begin n_fail++; $display("FAIL frame_load_time got %0d exp 4", time_val); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL frame_full_ready got %b exp 0", pix_ready); end
      n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL frame_no_error got %b exp 0", frame_error); end
      n_checks++; if (spike_times !== 16'h8888 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL frame_before_swap got st=%h fv=%b exp st=8888 fv=0", spike_times, frame_valid); end
      repeat (3) tick();
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL frame_wrap_ready got %b exp 0", pix_ready); end
      tick();
      n_checks++; if (spike_times !== 16'h8640) begin n_fail++; $display("FAIL frame_spike_times got %h exp 8640", spike_times); end
      n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL frame_start_pulse got %b exp 1", frame_start); end
      n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL frame_valid got %b exp 1", frame_valid); end
      n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL frame_count got %0d exp 1", frame_count); end
      n_checks++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL frame_ready_after_swap got %b exp 1", pix_ready); end
   endtask

   task automatic test_empty_window();
      for (int i = 1; i <= 7; i++) begin
         tick();
         n_checks++;
         if (spike_times !== 16'h8640 || frame_valid !== 1'b1 || frame_start !== 1'b0) begin
            n_fail++; $display("FAIL window_stable tv=%0d got st=%h fv=%b fs=%b exp st=8640 fv=1 fs=0", time_val, spike_times, frame_valid, frame_start);
         end
      end
      tick();
      n_checks++; if (spike_times !== 16'h8888) begin n_fail++; $display("FAIL empty_spike_times got %h exp 8888", spike_times); end
      n_checks++; if (frame_valid !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL empty_flags got fv=%b fs=%b exp 0 0", frame_valid, frame_start); end
      n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL empty_frame_count got %0d exp 1", frame_count); end
   endtask

   task automatic test_late_final();
      repeat (4) tick();
      n_checks++; if (pix_ready !== 1'b1 || time_val !== 4'd4) begin n_fail++; $display("FAIL late_start got ready=%b tv=%0d exp 1 4", pix_ready, time_val); end
      send_pix(8'd50,  1'b0);
      send_pix(8'd150, 1'b0);
      send_pix(8'd250, 1'b0);
      send_pix(8'd0,   1'b1);
      n_checks++; if (time_val !== 4'd0) begin n_fail++; $display("FAIL late_wrap_tv got %0d exp 0", time_val); end
      n_checks++; if (frame_valid !== 1'b0 || frame_start !== 1'b0 || spike_times !== 16'h8888) begin
         n_fail++; $display("FAIL late_no_swap got fv=%b fs=%b st=%h exp 0 0 8888", frame_valid, frame_start, spike_times);
      end
      for (int i = 1; i <= 8; i++) begin
         n_checks++;
         if (pix_ready !== 1'b0 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL late_wait step %0d got ready=%b fv=%b exp 0 0", i, pix_ready, frame_valid); end
         tick();
      end
      n_checks++; if (spike_times !== 16'h8036) begin n_fail++; $display("FAIL late_spike_times got %h exp 8036", spike_times); end
      n_checks++; if (frame_start !== 1'b1 || frame_valid !== 1'b1) begin n_fail++; $display("FAIL late_flags got fs=%b fv=%b exp 1 1", frame_start, frame_valid); end
      n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL late_frame_count got %0d exp 2", frame_count); end
   endtask

   task automatic test_short_frame();
      int err_pulses = 0;
      send_pix(8'd200, 1'b0);
      send_pix(8'd255, 1'b1);
      n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL short_error_pulse got %b exp 1", frame_error); end
      n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL short_ready got %b exp 0", pix_ready); end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (frame_error === 1'b1) err_pulses++;
      end
      n_checks++; if (err_pulses !== 0) begin n_fail++; $display("FAIL short_error_once got %0d extra pulses exp 0", err_pulses); end
      n_checks++; if (time_val !== 4'd0 || spike_times !== 16'h8801) begin n_fail++; $display("FAIL short_spike_times got tv=%0d st=%h exp 0 8801", time_val, spike_times); end
      n_checks++; if (frame_start !== 1'b1 || frame_count !== 16'd3) begin n_fail++; $display("FAIL short_flags got fs=%b fc=%0d exp 1 3", frame_start, frame_count); end
   endtask

   task automatic test_reset_mid_load();
      send_pix(8'd100, 1'b0);
      send_pix(8'd100, 1'b0);
      rst = 1'b1;
      tick();
      n_checks++; if (time_val !== 4'd0 || spike_times !== 16'h8888) begin n_fail++; $display("FAIL midrst_state got tv=%0d st=%h exp 0 8888", time_val, spike_times); end
      n_checks++; if (frame_valid !== 1'b0 || frame_count !== 16'd0 || pix_ready !== 1'b0) begin
         n_fail++; $display("FAIL midrst_flags got fv=%b fc=%0d ready=%b exp 0 0 0", frame_valid, frame_count, pix_ready);
      end
      rst = 1'b0;
      send_pix(8'd255, 1'b0);
      send_pix(8'd255, 1'b0);
      send_pix(8'd255, 1'b0);
      send_pix(8'd255, 1'b1);
      n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL midrst_no_error got %b exp 0", frame_error); end
      repeat (4) tick();
      n_checks++; if (spike_times !== 16'h0000) begin n_fail++; $display("FAIL midrst_spike_times got %h exp 0000", spike_times); end
      n_checks++; if (frame_start !== 1'b1 || frame_count !== 16'd1 || frame_valid !== 1'b1) begin
         n_fail++; $display("FAIL midrst_flags_after got fs=%b fc=%0d fv=%b exp 1 1 1", frame_start, frame_count, frame_valid);
      end
   endtask

   initial begin
      test_reset();
      sync_zero();
      test_frame();
      test_empty_window();
      test_late_final();
      test_short_frame();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
